// File: rtl/axi_ring_pkg.sv
// Shared AXI3 constants and the write-path FSM encoding for the multi-channel ring writer.
package axi_ring_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

endpackage

// File: rtl/axi_ring_fifo.sv
// Show-ahead 32-bit FIFO, depth 2**AW, with synchronous flush and occupancy count.
module axi_ring_fifo #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   din,
    output logic [31:0]   dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 2 ** AW;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_ring_wr_mc.sv
// Multi-channel sample writer: per-channel FIFOs, round-robin burst arbiter, ring-buffer offsets, one AXI3 HP port.
// Optional AXI_RING_TESTPAT_EN adds test_mode inputs that replace channel data with a per-channel counter.
module axi_ring_wr_mc
    import axi_ring_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int BURST_LEN = 16,
    parameter int FIFO_AW   = 5,
    parameter int AXI_ID    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*32-1:0] s_data,
    input  logic [NCH-1:0]    s_en,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH*32-1:0] base,
    input  logic [NCH*18-1:0] size,
    input  logic [NCH-1:0]    ovf_clr,
`ifdef AXI_RING_TESTPAT_EN
    input  logic [NCH-1:0]    test_mode,
`endif
    output logic [NCH*18-1:0] acnt,
    output logic [NCH*32-1:0] bcnt,
    output logic [NCH-1:0]    ovf,
    output logic [15:0]       berr_cnt,
    output logic [31:0]       awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [5:0]        awid,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic [3:0]        awqos,
    output logic [1:0]        awlock,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    output logic [5:0]        wid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    input  logic [5:0]        bid,
    output logic              bready
);

    localparam int              CW          = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int              BW          = $clog2(BURST_LEN);
    localparam int              CNTW        = FIFO_AW + 1;
    localparam logic [CNTW-1:0] BURST_CNT   = CNTW'(BURST_LEN);
    localparam logic [24:0]     BURST_BYTES = 25'(BURST_LEN * 4);
    localparam logic [BW-1:0]   LAST_BEAT   = BW'(BURST_LEN - 1);

    state_t state, state_nxt;

    logic [CW-1:0]        gnt, rr_ptr, pick, cand;
    logic                 any_req, launch, b_done;
    logic [NCH-1:0]       req, push, pop, full, empty, flush, s_en_eff, owned;
    logic [NCH*32-1:0]    din_all, dout_all;
    logic [NCH*24-1:0]    off_all;
    logic [NCH*CNTW-1:0]  cnt_all;
    logic [31:0]          awaddr_q;
    logic [17:0]          size_q;
    logic [BW-1:0]        beat;
    logic [15:0]          berr_q;
    logic [23:0]          off_sel;
    logic [24:0]          off_next, ring_bytes;
    logic                 wrap;
    logic                 unused_bid;

    assign unused_bid = ^bid;

    // First requester at or after rr_ptr; scanning downward lets the nearest one win.
    always_comb begin
        any_req = 1'b0;
        pick    = rr_ptr;
        cand    = rr_ptr;
        for (int i = NCH - 1; i >= 0; i--) begin
            cand = CW'((int'(rr_ptr) + i) % NCH);
            if (req[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        b_done    = 1'b0;
        case (state)
            ST_IDLE: if (any_req) begin
                state_nxt = ST_AW;
                launch    = 1'b1;
            end
            ST_AW:   if (awready) state_nxt = ST_W;
            ST_W:    if (wready && (beat == LAST_BEAT)) state_nxt = ST_B;
            ST_B:    if (bvalid) begin
                state_nxt = ST_IDLE;
                b_done    = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign awvalid  = (state == ST_AW);
    assign wvalid   = (state == ST_W);
    assign bready   = (state == ST_B);
    assign wlast    = (state == ST_W) && (beat == LAST_BEAT);
    assign awaddr   = awaddr_q;
    assign awlen    = 4'(BURST_LEN - 1);
    assign awsize   = AXI_SIZE_4B;
    assign awburst  = AXI_BURST_INCR;
    assign awid     = 6'(AXI_ID);
    assign awcache  = AXI_CACHE_BUF;
    assign awprot   = 3'd0;
    assign awqos    = 4'd0;
    assign awlock   = 2'd0;
    assign wdata    = dout_all[gnt*32 +: 32];
    assign wstrb    = 4'hF;
    assign wid      = 6'(AXI_ID);
    assign berr_cnt = berr_q;

    assign off_sel    = off_all[gnt*24 +: 24];
    assign off_next   = {1'b0, off_sel} + BURST_BYTES;
    assign ring_bytes = {1'b0, size_q, 6'd0};
    assign wrap       = (off_next >= ring_bytes);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            rr_ptr   <= '0;
            awaddr_q <= '0;
            size_q   <= '0;
            beat     <= '0;
            berr_q   <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                gnt      <= pick;
                rr_ptr   <= (pick == CW'(NCH - 1)) ? '0 : pick + 1'b1;
                awaddr_q <= base[pick*32 +: 32] + {8'd0, off_all[pick*24 +: 24]};
                size_q   <= size[pick*18 +: 18];
                beat     <= '0;
            end else if ((state == ST_W) && wready) begin
                beat <= beat + 1'b1;
            end
            if (b_done && (bresp != AXI_RESP_OKAY) && (berr_q != 16'hFFFF))
                berr_q <= berr_q + 1'b1;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [23:0] off_r;
        logic [31:0] bcnt_r;
        logic        ovf_r;

`ifdef AXI_RING_TESTPAT_EN
        logic [31:0] tp_cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                          tp_cnt <= '0;
            else if (push[c] && test_mode[c]) tp_cnt <= tp_cnt + 1'b1;
        end
        assign s_en_eff[c]          = test_mode[c] ? ch_en[c] : s_en[c];
        assign din_all[c*32 +: 32]  = test_mode[c] ? tp_cnt : s_data[c*32 +: 32];
`else
        assign s_en_eff[c]          = s_en[c];
        assign din_all[c*32 +: 32]  = s_data[c*32 +: 32];
`endif

        // A disabled channel stays flushed unless it still owns the in-flight burst.
        assign owned[c] = (state != ST_IDLE) && (gnt == CW'(c));
        assign flush[c] = ~ch_en[c] & ~owned[c];
        assign push[c]  = s_en_eff[c] & ch_en[c] & ~full[c];
        assign pop[c]   = (state == ST_W) && wready && (gnt == CW'(c));
        assign req[c]   = ch_en[c] && (cnt_all[c*CNTW +: CNTW] >= BURST_CNT);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                off_r  <= '0;
                bcnt_r <= '0;
                ovf_r  <= 1'b0;
            end else begin
                if (flush[c])                        off_r <= '0;
                else if (b_done && (gnt == CW'(c)))  off_r <= wrap ? 24'd0 : off_next[23:0];
                if (b_done && (gnt == CW'(c)) && wrap) bcnt_r <= bcnt_r + 1'b1;
                if (s_en_eff[c] && ch_en[c] && full[c]) ovf_r <= 1'b1;
                else if (ovf_clr[c])                    ovf_r <= 1'b0;
            end
        end

        assign off_all[c*24 +: 24] = off_r;
        assign acnt[c*18 +: 18]    = off_r[23:6];
        assign bcnt[c*32 +: 32]    = bcnt_r;
        assign ovf[c]              = ovf_r;

        axi_ring_fifo #(.AW(FIFO_AW)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush[c]),
            .push  (push[c]),
            .pop   (pop[c]),
            .din   (din_all[c*32 +: 32]),
            .dout  (dout_all[c*32 +: 32]),
            .count (cnt_all[c*CNTW +: CNTW]),
            .full  (full[c]),
            .empty (empty[c])
        );
    end

endmodule

// File: tb/tb_axi_ring_wr_mc.sv
// Directed bench for axi_ring_wr_mc: AXI slave model, handshake monitor, one task per scenario.
module tb_axi_ring_wr_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_data;
    logic [1:0]  s_en, ch_en, ovf_clr;
    logic [63:0] base;
    logic [35:0] size;
`ifdef AXI_RING_TESTPAT_EN
    logic [1:0]  test_mode;
`endif
    logic [35:0] acnt;
    logic [63:0] bcnt;
    logic [1:0]  ovf;
    logic [15:0] berr_cnt;
    logic [31:0] awaddr, wdata;
    logic [3:0]  awlen, awcache, awqos, wstrb;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock, bresp;
    logic [5:0]  awid, wid, bid;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    logic aw_rdy, w_rdy;
    int   b_hs;
    int   err_burst;
    int   n_vec = 0;
    int   n_err = 0;
    int   proto_err;
    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];

    assign awready = aw_rdy;
    assign wready  = w_rdy;
    assign bid     = 6'd0;
    assign bresp   = (bvalid && (b_hs == err_burst)) ? 2'b10 : 2'b00;

    always #5 clk = ~clk;

    axi_ring_wr_mc #(.NCH(2), .BURST_LEN(16), .FIFO_AW(5), .AXI_ID(0)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_en(s_en), .ch_en(ch_en),
        .base(base), .size(size), .ovf_clr(ovf_clr),
`ifdef AXI_RING_TESTPAT_EN
        .test_mode(test_mode),
`endif
        .acnt(acnt), .bcnt(bcnt), .ovf(ovf), .berr_cnt(berr_cnt),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
        .awcache(awcache), .awprot(awprot), .awqos(awqos), .awlock(awlock),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wid(wid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bid(bid), .bready(bready)
    );

    // Slave: one response per wlast handshake; bresp picked by b_hs before it advances.
    always @(posedge clk) begin
        if (rst) begin
            bvalid <= 1'b0;
            b_hs   <= 0;
        end else begin
            if (wvalid && wready && wlast) bvalid <= 1'b1;
            else if (bvalid && bready)     bvalid <= 1'b0;
            if (bvalid && bready) b_hs <= b_hs + 1;
        end
    end

    bit          aw_open, aw_wait;
    int          beat_i;
    logic [31:0] aw_last;
    always @(negedge clk) begin
        if (rst) begin
            aw_open = 1'b0;
            aw_wait = 1'b0;
            beat_i  = 0;
        end else begin
            if (awvalid) begin
                if (awlen !== 4'd15 || awsize !== 3'b010 || awburst !== 2'b01 ||
                    awcache !== 4'b0011 || awid !== 6'd0 || awlock !== 2'd0) proto_err++;
                if (aw_open) proto_err++;
                if (aw_wait && awaddr !== aw_last) proto_err++;
                aw_last = awaddr;
                if (awready) begin
                    aw_q.push_back(awaddr);
                    aw_open = 1'b1;
                    aw_wait = 1'b0;
                end else begin
                    aw_wait = 1'b1;
                end
            end
            if (wvalid) begin
                if (!aw_open || wstrb !== 4'hF || wid !== 6'd0) proto_err++;
                if (wready) begin
                    w_q.push_back(wdata);
                    if (wlast !== (beat_i == 15)) proto_err++;
                    if (wlast === 1'b1) begin
                        beat_i  = 0;
                        aw_open = 1'b0;
                    end else begin
                        beat_i++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_data = '0; s_en = '0; ch_en = '0; ovf_clr = '0; base = '0; size = '0;
`ifdef AXI_RING_TESTPAT_EN
        test_mode = '0;
`endif
        aw_rdy = 1'b1; w_rdy = 1'b1; err_burst = -1;
        repeat (3) tick();
        aw_q.delete();
        w_q.delete();
        proto_err = 0;
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_b(input int n, input int budget, output bit ok);
        int k = 0;
        while (b_hs < n && k < budget) begin
            tick();
            k++;
        end
        ok = (b_hs >= n);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if ({awvalid, wvalid, bready} !== 3'b000) begin n_err++; $display("FAIL reset_valids got %b exp 000", {awvalid, wvalid, bready}); end
        n_vec++; if (acnt !== 36'd0) begin n_err++; $display("FAIL reset_acnt got %h exp 0", acnt); end
        n_vec++; if (bcnt !== 64'd0) begin n_err++; $display("FAIL reset_bcnt got %h exp 0", bcnt); end
        n_vec++; if (ovf !== 2'b00) begin n_err++; $display("FAIL reset_ovf got %b exp 00", ovf); end
        n_vec++; if (berr_cnt !== 16'd0) begin n_err++; $display("FAIL reset_berr got %0d exp 0", berr_cnt); end
    endtask

    task automatic test_single_ring();
        bit ok;
        do_reset();
        base[31:0] = 32'h1000_0000;
        size[17:0] = 18'd1;
        ch_en = 2'b01;
        for (int i = 0; i < 48; i++) begin
            s_data[31:0] = 32'(i);
            s_en = 2'b01;
            tick();
        end
        s_en = '0;
        wait_b(3, 400, ok);
        repeat (3) tick();
        n_vec++; if (!ok) begin n_err++; $display("FAIL single_timeout got %0d bursts exp 3", b_hs); end
        n_vec++; if (aw_q.size() !== 3) begin n_err++; $display("FAIL single_aw_count got %0d exp 3", aw_q.size()); end
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (aw_q[k] !== 32'h1000_0000) begin n_err++; $display("FAIL single_awaddr[%0d] got %h exp 10000000", k, aw_q[k]); end
        end
        n_vec++; if (w_q.size() !== 48) begin n_err++; $display("FAIL single_beats got %0d exp 48", w_q.size()); end
        for (int i = 0; i < 48; i++) begin
            n_vec++; if (w_q[i] !== 32'(i)) begin n_err++; $display("FAIL single_data[%0d] got %h exp %h", i, w_q[i], 32'(i)); end
        end
        n_vec++; if (bcnt[31:0] !== 32'd3) begin n_err++; $display("FAIL single_bcnt0 got %0d exp 3", bcnt[31:0]); end
        n_vec++; if (acnt[17:0] !== 18'd0) begin n_err++; $display("FAIL single_acnt0 got %0d exp 0", acnt[17:0]); end
        n_vec++; if (proto_err !== 0) begin n_err++; $display("FAIL single_protocol got %0d exp 0", proto_err); end
    endtask

    task automatic test_two_channels();
        bit ok;
        logic [31:0] exp_a, exp_d;
        int ch, j;
        do_reset();
        base = {32'h2000_0000, 32'h1000_0000};
        size = {18'd4, 18'd4};
        ch_en = 2'b11;
        for (int n = 0; n < 80; n++) begin
            s_data = {32'h8000_0000 + 32'(n), 32'(n)};
            s_en = 2'b11;
            tick();
            s_en = 2'b00;
            repeat (3) tick();
        end
        wait_b(10, 600, ok);
        repeat (3) tick();
        n_vec++; if (!ok) begin n_err++; $display("FAIL rr_timeout got %0d bursts exp 10", b_hs); end
        n_vec++; if (aw_q.size() !== 10) begin n_err++; $display("FAIL rr_aw_count got %0d exp 10", aw_q.size()); end
        for (int k = 0; k < 10; k++) begin
            ch = k % 2;
            j  = k / 2;
            exp_a = (ch == 1 ? 32'h2000_0000 : 32'h1000_0000) + 32'((j % 4) * 64);
            n_vec++; if (aw_q[k] !== exp_a) begin n_err++; $display("FAIL rr_awaddr[%0d] got %h exp %h", k, aw_q[k], exp_a); end
            for (int b = 0; b < 16; b++) begin
                exp_d = (ch == 1 ? 32'h8000_0000 : 32'h0) + 32'(j * 16 + b);
                n_vec++; if (w_q[k*16+b] !== exp_d) begin n_err++; $display("FAIL rr_data[%0d] got %h exp %h", k*16+b, w_q[k*16+b], exp_d); end
            end
        end
        n_vec++; if (bcnt !== {32'd1, 32'd1}) begin n_err++; $display("FAIL rr_bcnt got %h exp 0000000100000001", bcnt); end
        n_vec++; if (acnt !== {18'd1, 18'd1}) begin n_err++; $display("FAIL rr_acnt got %h exp %h", acnt, {18'd1, 18'd1}); end
        n_vec++; if (ovf !== 2'b00) begin n_err++; $display("FAIL rr_ovf got %b exp 00", ovf); end
        n_vec++; if (proto_err !== 0) begin n_err++; $display("FAIL rr_protocol got %0d exp 0", proto_err); end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        base[31:0] = 32'h1000_0000;
        size[17:0] = 18'd4;
        ch_en = 2'b01;
        aw_rdy = 1'b0;
        w_rdy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            s_data[31:0] = 32'(i);
            s_en = 2'b01;
            tick();
        end
        s_en = '0;
        n_vec++; if (ovf !== 2'b01) begin n_err++; $display("FAIL ovf_set got %b exp 01", ovf); end
        ovf_clr = 2'b01; tick(); ovf_clr = 2'b00;
        n_vec++; if (ovf !== 2'b00) begin n_err++; $display("FAIL ovf_clr got %b exp 00", ovf); end
        ovf_clr = 2'b01; s_en = 2'b01; s_data[31:0] = 32'd100; tick();
        ovf_clr = 2'b00; s_en = 2'b00;
        n_vec++; if (ovf !== 2'b01) begin n_err++; $display("FAIL ovf_set_wins got %b exp 01", ovf); end
        ovf_clr = 2'b01; tick(); ovf_clr = 2'b00;
        aw_rdy = 1'b1;
        w_rdy = 1'b1;
        wait_b(2, 200, ok);
        repeat (3) tick();
        n_vec++; if (!ok) begin n_err++; $display("FAIL ovf_timeout got %0d bursts exp 2", b_hs); end
        n_vec++; if (aw_q.size() !== 2 || aw_q[0] !== 32'h1000_0000 || aw_q[1] !== 32'h1000_0040) begin
            n_err++; $display("FAIL ovf_awaddr got n=%0d %h %h exp 2 10000000 10000040", aw_q.size(), aw_q[0], aw_q[1]);
        end
        n_vec++; if (w_q.size() !== 32) begin n_err++; $display("FAIL ovf_beats got %0d exp 32", w_q.size()); end
        for (int i = 0; i < 32; i++) begin
            n_vec++; if (w_q[i] !== 32'(i)) begin n_err++; $display("FAIL ovf_data[%0d] got %h exp %h", i, w_q[i], 32'(i)); end
        end
        n_vec++; if (ovf !== 2'b00) begin n_err++; $display("FAIL ovf_final got %b exp 00", ovf); end
        n_vec++; if (proto_err !== 0) begin n_err++; $display("FAIL ovf_protocol got %0d exp 0", proto_err); end
    endtask

    task automatic test_bresp_err();
        bit ok;
        do_reset();
        base[31:0] = 32'h1000_0000;
        size[17:0] = 18'd4;
        ch_en = 2'b01;
        err_burst = 0;
        for (int i = 0; i < 32; i++) begin
            s_data[31:0] = 32'(i);
            s_en = 2'b01;
            tick();
        end
        s_en = '0;
        wait_b(2, 300, ok);
        repeat (3) tick();
        n_vec++; if (!ok) begin n_err++; $display("FAIL berr_timeout got %0d bursts exp 2", b_hs); end
        n_vec++; if (berr_cnt !== 16'd1) begin n_err++; $display("FAIL berr_cnt got %0d exp 1", berr_cnt); end
        n_vec++; if (acnt[17:0] !== 18'd2) begin n_err++; $display("FAIL berr_acnt0 got %0d exp 2", acnt[17:0]); end
        n_vec++; if (aw_q[1] !== 32'h1000_0040) begin n_err++; $display("FAIL berr_awaddr1 got %h exp 10000040", aw_q[1]); end
        n_vec++; if (bcnt[31:0] !== 32'd0) begin n_err++; $display("FAIL berr_bcnt0 got %0d exp 0", bcnt[31:0]); end
    endtask

    task automatic test_disable_mid_burst();
        bit ok;
        int k;
        do_reset();
        base[31:0] = 32'h1000_0000;
        size[17:0] = 18'd4;
        ch_en = 2'b01;
        w_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_data[31:0] = 32'(i);
            s_en = 2'b01;
            tick();
        end
        s_en = '0;
        k = 0;
        while (!wvalid && k < 50) begin
            tick();
            k++;
        end
        n_vec++; if (wvalid !== 1'b1) begin n_err++; $display("FAIL dis_wvalid got %b exp 1", wvalid); end
        w_rdy = 1'b1;
        repeat (5) tick();
        ch_en = 2'b00;
        wait_b(1, 100, ok);
        repeat (3) tick();
        n_vec++; if (!ok) begin n_err++; $display("FAIL dis_timeout got %0d bursts exp 1", b_hs); end
        n_vec++; if (w_q.size() !== 16) begin n_err++; $display("FAIL dis_beats got %0d exp 16", w_q.size()); end
        n_vec++; if (acnt[17:0] !== 18'd0) begin n_err++; $display("FAIL dis_acnt0 got %0d exp 0", acnt[17:0]); end
        n_vec++; if (bcnt[31:0] !== 32'd0) begin n_err++; $display("FAIL dis_bcnt0 got %0d exp 0", bcnt[31:0]); end
        ch_en = 2'b01;
        for (int i = 0; i < 16; i++) begin
            s_data[31:0] = 32'd200 + 32'(i);
            s_en = 2'b01;
            tick();
        end
        s_en = '0;
        wait_b(2, 200, ok);
        repeat (3) tick();
        n_vec++; if (!ok) begin n_err++; $display("FAIL dis_reen_timeout got %0d bursts exp 2", b_hs); end
        n_vec++; if (aw_q[1] !== 32'h1000_0000) begin n_err++; $display("FAIL dis_reen_awaddr got %h exp 10000000", aw_q[1]); end
        for (int i = 0; i < 32; i++) begin
            n_vec++;
            if (w_q[i] !== ((i < 16) ? 32'(i) : 32'd200 + 32'(i - 16))) begin
                n_err++; $display("FAIL dis_data[%0d] got %h exp %h", i, w_q[i], (i < 16) ? 32'(i) : 32'd200 + 32'(i - 16));
            end
        end
        n_vec++; if (proto_err !== 0) begin n_err++; $display("FAIL dis_protocol got %0d exp 0", proto_err); end
    endtask

`ifdef AXI_RING_TESTPAT_EN
    task automatic test_testpat();
        bit ok;
        do_reset();
        base[31:0] = 32'h1000_0000;
        size[17:0] = 18'd4;
        test_mode = 2'b01;
        ch_en = 2'b01;
        wait_b(3, 300, ok);
        test_mode = 2'b00;
        ch_en = 2'b00;
        repeat (3) tick();
        n_vec++; if (!ok) begin n_err++; $display("FAIL tp_timeout got %0d bursts exp 3", b_hs); end
        for (int i = 0; i < 48; i++) begin
            n_vec++; if (w_q[i] !== 32'(i)) begin n_err++; $display("FAIL tp_data[%0d] got %h exp %h", i, w_q[i], 32'(i)); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_ring();
        test_two_channels();
        test_overflow();
        test_bresp_err();
        test_disable_mid_burst();
`ifdef AXI_RING_TESTPAT_EN
        test_testpat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
